// File: rtl/luhn_engine.sv
// luhn_engine: streaming Luhn (mod-10) check-digit engine, one decimal digit per
// cycle, most significant digit first.
//
// Parameters:
//   N_DIGITS  payload length in digits (1..63)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   digit strobe
//   in_num     digit value (legal 0..9)
//   in_mode    0 = generate, 1 = validate; sampled on digit 0 of a frame only
//   busy       frame partially received
//   out_valid  one-cycle result pulse
//   out_digit  computed / expected check digit (0 when out_valid low or on error)
//   out_pass   validate mode: frame checks out
//   out_err    frame aborted or contained a non-decimal digit
module luhn_engine #(
  parameter int unsigned N_DIGITS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_num,
  input  logic       in_mode,
  output logic       busy,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_pass,
  output logic       out_err
);

  localparam int unsigned CNT_W = $clog2(N_DIGITS + 2);

  localparam logic [CNT_W-1:0] LastGen = CNT_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] LastVal = CNT_W'(N_DIGITS);
  // Index parity of the doubled payload digits (rightmost payload digit is doubled).
  localparam logic DblPar = 1'((N_DIGITS - 1) % 2);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e           state_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       acc_q;
  logic             err_q;

  // Frame context as seen by the digit on in_num this cycle. In idle the incoming
  // digit is digit 0 of a new frame, so the context is taken fresh.
  logic             cur_mode;
  logic [CNT_W-1:0] cur_idx;
  logic [3:0]       cur_acc;
  logic             cur_err;

  logic             digit_bad;
  logic             dbl;
  logic [4:0]       dbl5;
  logic [4:0]       dbl_val;
  logic [3:0]       act;
  logic [4:0]       sum5;
  logic [4:0]       sum_sub;
  logic [3:0]       nxt;
  logic             last;
  logic             frame_err;
  logic [3:0]       pay_sum;
  logic [3:0]       chk;

  always_comb begin
    cur_mode  = mode_q;
    cur_idx   = cnt_q;
    cur_acc   = acc_q;
    cur_err   = err_q;
    if (state_q == StIdle) begin
      cur_mode = in_mode;
      cur_idx  = '0;
      cur_acc  = 4'd0;
      cur_err  = 1'b0;
    end

    digit_bad = in_num > 4'd9;
    dbl       = (cur_idx < LastVal) && (cur_idx[0] == DblPar);
    dbl5      = {in_num, 1'b0};
    dbl_val   = (in_num <= 4'd4) ? dbl5 : dbl5 - 5'd9;

    act = in_num;
    if (digit_bad) begin
      act = 4'd0;
    end else if (dbl) begin
      act = dbl_val[3:0];
    end

    // Running sum kept mod 10; act <= 9 so one conditional subtract suffices.
    sum5    = {1'b0, cur_acc} + {1'b0, act};
    sum_sub = sum5 - 5'd10;
    nxt     = (sum5 >= 5'd10) ? sum_sub[3:0] : sum5[3:0];

    last      = cur_idx == (cur_mode ? LastVal : LastGen);
    frame_err = cur_err | digit_bad;
    // Validate mode: payload sum is the accumulator before the check digit is added.
    pay_sum   = cur_mode ? cur_acc : nxt;
    chk       = (pay_sum == 4'd0) ? 4'd0 : 4'd10 - pay_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= 4'd0;
      err_q     <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_digit <= 4'd0;
      out_pass  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_digit <= 4'd0;
      out_pass  <= 1'b0;
      out_err   <= 1'b0;
      if (in_valid) begin
        if (last) begin
          out_valid <= 1'b1;
          out_digit <= frame_err ? 4'd0 : chk;
          out_pass  <= cur_mode && !frame_err && (nxt == 4'd0);
          out_err   <= frame_err;
          state_q   <= StIdle;
          busy      <= 1'b0;
          cnt_q     <= '0;
          acc_q     <= 4'd0;
          err_q     <= 1'b0;
        end else begin
          state_q <= StAccum;
          busy    <= 1'b1;
          mode_q  <= cur_mode;
          cnt_q   <= cur_idx + CNT_W'(1);
          acc_q   <= nxt;
          err_q   <= frame_err;
        end
      end else if (state_q == StAccum) begin
        // Strobe dropped mid-frame: abort.
        out_valid <= 1'b1;
        out_err   <= 1'b1;
        state_q   <= StIdle;
        busy      <= 1'b0;
        cnt_q     <= '0;
        acc_q     <= 4'd0;
        err_q     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_luhn_engine.sv
// Bench for luhn_engine: two instances (N_DIGITS=10 and 15), directed frames from
// the test plan followed by random frames, all scored against a Luhn model.
module tb_luhn_engine;

  typedef struct {
    int         cyc;
    logic [3:0] dig;
    logic       pass;
    logic       err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      iv;
  logic [1:0]      im;
  logic [1:0][3:0] inum;
  wire  [1:0]      busy_w;
  wire  [1:0]      ov;
  wire  [1:0]      pass_w;
  wire  [1:0]      err_w;
  wire  [1:0][3:0] dig_w;

  int         cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;
  logic [1:0] exp_busy;
  exp_t       q0[$];
  exp_t       q1[$];

  luhn_engine #(.N_DIGITS(10)) u_dut10 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_num(inum[0]), .in_mode(im[0]),
    .busy(busy_w[0]), .out_valid(ov[0]), .out_digit(dig_w[0]), .out_pass(pass_w[0]),
    .out_err(err_w[0])
  );

  luhn_engine #(.N_DIGITS(15)) u_dut15 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_num(inum[1]), .in_mode(im[1]),
    .busy(busy_w[1]), .out_valid(ov[1]), .out_digit(dig_w[1]), .out_pass(pass_w[1]),
    .out_err(err_w[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Luhn reference: weights taken from the right end of the payload.
  function automatic exp_t model(input int n, input bit mode, input int d[$]);
    exp_t r;
    int   sum = 0;
    int   v;
    int   chk;
    bit   bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      v = d[i];
      if (v > 9) begin
        bad = 1'b1;
        v = 0;
      end else if (((n - 1 - i) % 2) == 0) begin
        v = v * 2;
        if (v > 9) v -= 9;
      end
      sum += v;
    end
    chk = (10 - (sum % 10)) % 10;
    if (mode && d[n] > 9) bad = 1'b1;
    r.cyc  = 0;
    r.err  = bad;
    r.dig  = bad ? 4'd0 : 4'(chk);
    r.pass = mode && !bad && (d[n] == chk);
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      for (int s = 0; s < 2; s++) begin
        exp_t e;
        bit   hit;
        hit = 1'b0;
        if (s == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin
          e = q0.pop_front();
          hit = 1'b1;
        end
        if (s == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin
          e = q1.pop_front();
          hit = 1'b1;
        end
        if (hit) begin
          check_eq($sformatf("out_valid[%0d]", s), 32'(ov[s]), 32'd1);
          check_eq($sformatf("out_digit[%0d]", s), 32'(dig_w[s]), 32'(e.dig));
          check_eq($sformatf("out_pass[%0d]", s), 32'(pass_w[s]), 32'(e.pass));
          check_eq($sformatf("out_err[%0d]", s), 32'(err_w[s]), 32'(e.err));
        end else begin
          check_eq($sformatf("quiet_outs[%0d]", s),
                   32'({ov[s], dig_w[s], pass_w[s], err_w[s]}), 32'd0);
        end
        check_eq($sformatf("busy[%0d]", s), 32'(busy_w[s]), 32'(exp_busy[s]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int sel, input exp_t e);
    e.cyc = cyc;
    if (sel == 1) q1.push_back(e);
    else q0.push_back(e);
  endtask

  task automatic idle(input int k);
    iv = '0;
    repeat (k) step();
  endtask

  // Drives one frame; abort_at >= 1 drops the strobe at that digit index.
  task automatic send_frame(input int sel, input bit mode, input int d[$], input int abort_at);
    int   n;
    int   len;
    exp_t e;
    n   = (sel == 1) ? 15 : 10;
    len = n + int'(mode);
    e   = model(n, mode, d);
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        iv[sel]   = 1'b0;
        inum[sel] = 4'($urandom_range(0, 15));
        step();
        e.dig  = 4'd0;
        e.pass = 1'b0;
        e.err  = 1'b1;
        push_exp(sel, e);
        exp_busy[sel] = 1'b0;
        return;
      end
      iv[sel]   = 1'b1;
      inum[sel] = 4'(d[i]);
      im[sel]   = (i == 0) ? mode : 1'($urandom);
      step();
      if (i == len - 1) begin
        push_exp(sel, e);
        exp_busy[sel] = 1'b0;
      end else begin
        exp_busy[sel] = 1'b1;
      end
    end
    iv[sel] = 1'b0;
  endtask

  initial begin
    int   d[$];
    int   sel;
    int   n;
    int   len;
    int   ab;
    bit   mode;
    exp_t t;

    iv = '0;
    im = '0;
    inum = '0;
    exp_busy = '0;

    #3;
    check_eq("reset_outs", 32'({busy_w, ov, pass_w, err_w, dig_w}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // Generate / validate on N_DIGITS=10.
    d = '{7, 9, 9, 2, 7, 3, 9, 8, 7, 1};
    send_frame(0, 1'b0, d, -1);
    idle(2);
    d = '{7, 9, 9, 2, 7, 3, 9, 8, 7, 1, 3};
    send_frame(0, 1'b1, d, -1);
    idle(1);
    d = '{7, 9, 9, 2, 7, 3, 9, 8, 7, 1, 4};
    send_frame(0, 1'b1, d, -1);
    idle(2);

    // All zeros then all nines back to back on N_DIGITS=15.
    d = {};
    for (int i = 0; i < 15; i++) d.push_back(0);
    send_frame(1, 1'b0, d, -1);
    d = {};
    for (int i = 0; i < 15; i++) d.push_back(9);
    send_frame(1, 1'b0, d, -1);
    idle(2);

    // Abort after 6 digits, then a clean frame.
    d = {};
    for (int i = 0; i < 15; i++) d.push_back(i % 10);
    send_frame(1, 1'b0, d, 6);
    idle(1);
    send_frame(1, 1'b0, d, -1);
    idle(2);

    // Non-decimal digit mid-frame.
    d = {};
    for (int i = 0; i < 15; i++) d.push_back(int'($urandom_range(0, 9)));
    d[4] = 12;
    send_frame(1, 1'b0, d, -1);
    idle(2);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 5; i++) begin
      iv[1] = 1'b1;
      inum[1] = 4'(i + 1);
      im[1] = 1'b0;
      step();
      exp_busy[1] = 1'b1;
    end
    iv[1] = 1'b0;
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_busy", 32'(busy_w[1]), 32'd0);
    check_eq("rst_async_outs", 32'({ov, pass_w, err_w, dig_w}), 32'd0);
    #5 rst = 1'b0;
    exp_busy = '0;
    step();
    mon_en = 1'b1;
    idle(2);
    d = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3, 5, 8, 9, 7, 9, 3};
    send_frame(1, 1'b1, d, -1);
    idle(2);

    // Random frames.
    for (int f = 0; f < 60; f++) begin
      sel  = int'($urandom_range(0, 1));
      mode = 1'($urandom);
      n    = (sel == 1) ? 15 : 10;
      len  = n + int'(mode);
      d = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 24) == 0) d.push_back(int'($urandom_range(10, 15)));
        else d.push_back(int'($urandom_range(0, 9)));
      end
      if (mode && $urandom_range(0, 1) == 1) begin
        t = model(n, 1'b0, d);
        if (!t.err) d[n] = int'(t.dig);
      end
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, len - 1)) : -1;
      send_frame(sel, mode, d, ab);
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    check_eq("pending_pulses", 32'(q0.size() + q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
